// File: rtl/node_pkg.sv
// Shared node image layout, type codes, count limits and error-flag bit positions
// for the node stream unpacker and its field checker.
package node_pkg;

   localparam logic [7:0] NODE_PARTITION = 8'd0;
   localparam logic [7:0] NODE_CUT       = 8'd1;
   localparam logic [7:0] NODE_LEAF      = 8'd2;

   localparam int unsigned MAX_RULES_PER_NODE    = 32'd16;
   localparam int unsigned MAX_CHILDREN_PER_NODE = 32'd8;

   // Bit offsets of each field inside the LSB-first node image.
   localparam int OFF_NODE_TYPE   = 0;
   localparam int OFF_FLAGS       = 8;
   localparam int OFF_NODE_ID     = 16;
   localparam int OFF_RULE_COUNT  = 32;
   localparam int OFF_CHILD_COUNT = 64;
   localparam int OFF_CHILD_BASE  = 96;
   localparam int OFF_RULE_BASE   = 128;

   localparam int ERR_W         = 4;
   localparam int ERR_SHORT     = 0;
   localparam int ERR_LONG      = 1;
   localparam int ERR_BAD_TYPE  = 2;
   localparam int ERR_COUNT_OVF = 3;

   typedef struct packed {
      logic [31:0] rule_base;
      logic [31:0] child_base;
      logic [31:0] child_count;
      logic [31:0] rule_count;
      logic [15:0] node_id;
      logic [7:0]  flags;
      logic [7:0]  node_type;
   } node_s;

   function automatic logic is_known_type(input logic [7:0] node_type);
      return (node_type == NODE_PARTITION) || (node_type == NODE_CUT) ||
             (node_type == NODE_LEAF);
   endfunction

endpackage

// File: rtl/node_field_check.sv
// Combinational sanity check of an assembled node: unknown type code and
// rule/child counts that exceed the configured limits.
module node_field_check
   import node_pkg::*;
#(
   parameter int unsigned MAX_RULES    = MAX_RULES_PER_NODE,
   parameter int unsigned MAX_CHILDREN = MAX_CHILDREN_PER_NODE
) (
   input  node_s node,
   output logic  bad_type,
   output logic  count_ovf
);

   logic rule_ovf;
   logic child_ovf;
   logic leaf_with_children;
   logic unused_fields;

   assign bad_type = !is_known_type(node.node_type);

   assign rule_ovf           = node.rule_count > MAX_RULES;
   assign child_ovf          = node.child_count > MAX_CHILDREN;
   assign leaf_with_children = (node.node_type == NODE_LEAF) && (node.child_count != 32'd0);

   assign count_ovf = rule_ovf || child_ovf || leaf_with_children;

   // Payload fields carry no constraints at this level.
   assign unused_fields = ^{node.rule_base, node.child_base, node.node_id, node.flags};

endmodule

// File: rtl/node_stream_unpacker.sv
// Collects LSB-first beats of one node image, flags short/long framing and
// bad field values, and holds the assembled node until the consumer takes it.
module node_stream_unpacker
   import node_pkg::*;
#(
   parameter int          WORD_W       = 64,
   parameter int unsigned MAX_RULES    = MAX_RULES_PER_NODE,
   parameter int unsigned MAX_CHILDREN = MAX_CHILDREN_PER_NODE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output node_s             out_node,
   output logic [ERR_W-1:0]  out_err
);

   localparam int NODE_W = $bits(node_s);
   localparam int BEATS  = (NODE_W + WORD_W - 1) / WORD_W;
   localparam int CNT_W  = ($clog2(BEATS + 1) < 1) ? 1 : $clog2(BEATS + 1);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_DRAIN   = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NODE_W-1:0] img_q, img_d;
   logic              short_q, short_d;
   logic              long_q, long_d;
   logic              live_q, live_d;

   logic              accept;
   logic              bad_type;
   logic              count_ovf;

   // Input side: a beat moves on in_valid && in_ready; in_ready is low in HOLD
   // and during the first cycle after reset. Output side: the held node moves
   // on out_valid && out_ready, and out_node/out_err do not change before that.
   assign in_ready  = live_q && (state_q != ST_HOLD);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == ST_HOLD);
   assign out_node  = node_s'(img_q);

   assign live_d = 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      img_d   = img_q;
      short_d = short_q;
      long_d  = long_q;

      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               for (int i = 0; i < NODE_W; i++) begin
                  if (cnt_q == CNT_W'(i / WORD_W)) begin
                     img_d[i] = in_data[i % WORD_W];
                  end
               end

               if (cnt_q == LAST_BEAT) begin
                  if (in_last) begin
                     state_d = ST_HOLD;
                  end else begin
                     long_d  = 1'b1;
                     state_d = ST_DRAIN;
                  end
               end else if (in_last) begin
                  // Truncated image: nothing above the terminating beat survives.
                  for (int i = 0; i < NODE_W; i++) begin
                     if (CNT_W'(i / WORD_W) > cnt_q) begin
                        img_d[i] = 1'b0;
                     end
                  end
                  short_d = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_DRAIN: begin
            if (accept && in_last) begin
               state_d = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_COLLECT;
               cnt_d   = '0;
               img_d   = '0;
               short_d = 1'b0;
               long_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_COLLECT;
            cnt_d   = '0;
            img_d   = '0;
            short_d = 1'b0;
            long_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_COLLECT;
         cnt_q   <= '0;
         img_q   <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         img_q   <= img_d;
         short_q <= short_d;
         long_q  <= long_d;
         live_q  <= live_d;
      end
   end

   node_field_check #(
      .MAX_RULES    (MAX_RULES),
      .MAX_CHILDREN (MAX_CHILDREN)
   ) u_field_check (
      .node      (out_node),
      .bad_type  (bad_type),
      .count_ovf (count_ovf)
   );

   always_comb begin
      out_err                = '0;
      out_err[ERR_SHORT]     = short_q;
      out_err[ERR_LONG]      = long_q;
      out_err[ERR_BAD_TYPE]  = bad_type;
      out_err[ERR_COUNT_OVF] = count_ovf;
   end

endmodule

// File: tb/tb_node_stream_unpacker.sv
// Directed and randomized stimulus for node_stream_unpacker, checked against a
// field-level reference model through an expected-result queue.
module tb_node_stream_unpacker;
   import node_pkg::*;

   localparam int WORD_W = 64;
   localparam int NODE_W = $bits(node_s);
   localparam int BEATS  = (NODE_W + WORD_W - 1) / WORD_W;
   localparam int CW     = NODE_W + ERR_W;
   localparam int GUARD  = 200;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   node_s             out_node;
   logic [ERR_W-1:0]  out_err;

   int vectors;
   int miscompares;
   logic [CW-1:0] exp_q[$];

   node_stream_unpacker #(
      .WORD_W       (WORD_W),
      .MAX_RULES    (MAX_RULES_PER_NODE),
      .MAX_CHILDREN (MAX_CHILDREN_PER_NODE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_node  (out_node),
      .out_err   (out_err)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [WORD_W-1:0] rand_word();
      logic [WORD_W-1:0] w;
      for (int i = 0; i < WORD_W; i++) w[i] = 1'($urandom_range(0, 1));
      return w;
   endfunction

   function automatic node_s make_node(input logic [7:0] t, input logic [31:0] rc,
                                       input logic [31:0] cc);
      node_s n;
      n.node_type   = t;
      n.flags       = 8'($urandom);
      n.node_id     = 16'($urandom);
      n.rule_count  = rc;
      n.child_count = cc;
      n.child_base  = $urandom;
      n.rule_base   = $urandom;
      return n;
   endfunction

   // Reference: keep the bits carried by the beats actually sent, then apply
   // the framing and field rules to what is left.
   function automatic logic [CW-1:0] model(input node_s n, input int nbeats);
      logic [NODE_W-1:0] img;
      node_s             h;
      logic [ERR_W-1:0]  e;
      int                keep_bits;
      img       = n;
      keep_bits = ((nbeats < BEATS) ? nbeats : BEATS) * WORD_W;
      for (int i = 0; i < NODE_W; i++) if (i >= keep_bits) img[i] = 1'b0;
      h = img;
      e = '0;
      e[ERR_SHORT]     = (nbeats < BEATS);
      e[ERR_LONG]      = (nbeats > BEATS);
      e[ERR_BAD_TYPE]  = !(h.node_type == 8'd0 || h.node_type == 8'd1 || h.node_type == 8'd2);
      e[ERR_COUNT_OVF] = (h.rule_count > MAX_RULES_PER_NODE) ||
                         (h.child_count > MAX_CHILDREN_PER_NODE) ||
                         (h.node_type == 8'd2 && h.child_count != 32'd0);
      return {e, img};
   endfunction

   // ---------------- drivers (called at a falling edge) ----------------
   task automatic send_beat(input logic [WORD_W-1:0] data, input logic last);
      int guard;
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      guard    = 0;
      while (in_ready !== 1'b1 && guard < GUARD) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= GUARD) check("beat_accept_timeout", CW'(in_ready), CW'(1));
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = rand_word();
   endtask

   task automatic send_node(input node_s n, input int nbeats, input int gap_max,
                            input bit drain_chk);
      logic [NODE_W-1:0] img;
      logic [WORD_W-1:0] data;
      int                p;
      img = n;
      for (int k = 0; k < nbeats; k++) begin
         repeat ($urandom_range(0, gap_max)) begin
            in_valid = 1'b0;
            in_data  = rand_word();
            @(negedge clk);
         end
         for (int i = 0; i < WORD_W; i++) begin
            p       = k * WORD_W + i;
            data[i] = (p < NODE_W) ? img[p] : 1'($urandom_range(0, 1));
         end
         if (drain_chk && k >= BEATS) check("drain_in_ready", CW'(in_ready), CW'(1));
         send_beat(data, k == nbeats - 1);
      end
   endtask

   task automatic recv(input string tag, input int delay_max);
      int guard;
      out_ready = 1'b0;
      repeat ($urandom_range(0, delay_max)) @(negedge clk);
      out_ready = 1'b1;
      guard     = 0;
      while (out_valid !== 1'b1 && guard < GUARD) begin
         @(negedge clk);
         guard++;
      end
      if (out_valid !== 1'b1) begin
         check({tag, "_timeout"}, CW'(out_valid), CW'(1));
      end else if (exp_q.size() == 0) begin
         check({tag, "_unexpected"}, CW'(exp_q.size()), CW'(1));
      end else begin
         check(tag, {out_err, out_node}, exp_q.pop_front());
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      node_s         n;
      node_s         n2;
      logic [CW-1:0] held;
      int            nb;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      in_last     = 1'b0;
      out_ready   = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_out_valid", CW'(out_valid), CW'(0));
      check("rst_in_ready", CW'(in_ready), CW'(0));
      check("rst_out", {out_err, out_node}, CW'(0));
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", CW'(in_ready), CW'(0));
      @(negedge clk);
      check("ready_after_edge", CW'(in_ready), CW'(1));

      // Exact-length CUT node.
      n = make_node(NODE_CUT, 32'd2, 32'd4);
      exp_q.push_back(model(n, BEATS));
      send_node(n, BEATS, 0, 1'b0);
      check("exact_latency", CW'(out_valid), CW'(1));
      check("exact_err", CW'(out_err), CW'(4'b0000));
      check("exact_in_ready", CW'(in_ready), CW'(0));
      recv("exact", 0);
      check("exact_single", CW'(out_valid), CW'(0));

      // Terminated on beat 0.
      n = make_node(NODE_CUT, 32'd2, 32'd4);
      exp_q.push_back(model(n, 1));
      send_node(n, 1, 0, 1'b0);
      check("short_err", CW'(out_err), CW'(4'b0001));
      check("short_upper_zero", CW'(out_node >> WORD_W), CW'(0));
      recv("short", 2);

      // Three beats too many.
      n = make_node(NODE_CUT, 32'd2, 32'd4);
      exp_q.push_back(model(n, BEATS + 3));
      send_node(n, BEATS + 3, 0, 1'b1);
      check("long_err", CW'(out_err), CW'(4'b0010));
      recv("long", 1);

      // Unknown type with too many rules, then a leaf claiming a child.
      n = make_node(8'd3, MAX_RULES_PER_NODE + 32'd1, 32'd0);
      exp_q.push_back(model(n, BEATS));
      send_node(n, BEATS, 1, 1'b0);
      check("badtype_err", CW'(out_err), CW'(4'b1100));
      recv("badtype", 0);
      n = make_node(NODE_LEAF, 32'd3, 32'd1);
      exp_q.push_back(model(n, BEATS));
      send_node(n, BEATS, 1, 1'b0);
      check("leaf_err", CW'(out_err), CW'(4'b1000));
      recv("leaf", 0);

      // Consumer stalls 10 cycles while a beat is offered.
      n = make_node(NODE_PARTITION, 32'd5, 32'd7);
      exp_q.push_back(model(n, BEATS));
      send_node(n, BEATS, 0, 1'b0);
      held     = exp_q[0];
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = rand_word();
      for (int c = 0; c < 10; c++) begin
         check("stall_valid", CW'(out_valid), CW'(1));
         check("stall_in_ready", CW'(in_ready), CW'(0));
         check("stall_hold", {out_err, out_node}, held);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      recv("stall", 0);
      n = make_node(NODE_CUT, 32'd1, 32'd2);
      exp_q.push_back(model(n, BEATS));
      send_node(n, BEATS, 0, 1'b0);
      recv("after_stall", 0);

      // Two nodes queued back to back.
      n  = make_node(NODE_CUT, 32'd4, 32'd3);
      n2 = make_node(NODE_LEAF, 32'd9, 32'd0);
      exp_q.push_back(model(n, BEATS));
      exp_q.push_back(model(n2, BEATS));
      fork
         begin
            send_node(n, BEATS, 0, 1'b0);
            send_node(n2, BEATS, 0, 1'b0);
         end
         begin
            recv("b2b_first", 3);
            recv("b2b_second", 3);
         end
      join

      // Randomized traffic: arbitrary types, counts and framing.
      fork
         begin
            for (int r = 0; r < 24; r++) begin
               n = make_node(8'($urandom_range(0, 4)),
                             ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 20)),
                             32'($urandom_range(0, 10)));
               nb = $urandom_range(1, BEATS + 2);
               exp_q.push_back(model(n, nb));
               send_node(n, nb, 2, 1'b0);
            end
         end
         begin
            for (int r = 0; r < 24; r++) recv("random", 4);
         end
      join

      // Reset in the middle of a node, then while holding a result.
      n = make_node(NODE_CUT, 32'd2, 32'd4);
      send_beat(rand_word(), 1'b0);
      send_beat(rand_word(), 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", CW'(out_valid), CW'(0));
      check("rst_mid_ready", CW'(in_ready), CW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_node(n, BEATS, 0, 1'b0);
      check("pre_rst_hold_valid", CW'(out_valid), CW'(1));
      rst_n = 1'b0;
      #1;
      check("rst_hold_valid", CW'(out_valid), CW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n = make_node(NODE_CUT, 32'd2, 32'd4);
      exp_q.push_back(model(n, BEATS));
      send_node(n, BEATS, 0, 1'b0);
      check("post_rst_err", CW'(out_err), CW'(4'b0000));
      recv("post_rst", 0);
      repeat (3) @(negedge clk);
      check("no_extra_output", CW'(out_valid), CW'(0));
      check("queue_drained", CW'(exp_q.size()), CW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
